// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe: pipelined lane-split popcount with valid/ready and packet accumulation
module bit_population_counter_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE_W = 4,
  parameter int MAX_WORDS = 16,
  localparam int CNT_W = $clog2(WIDTH * MAX_WORDS) + 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             mode_zeros_i,
  input  logic             pkt_mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_last_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [CNT_W-1:0] data_o,
  output logic             data_ovf_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
);
  localparam int NUM_LANES = (WIDTH + LANE_W - 1) / LANE_W;
  localparam int PAD_W = NUM_LANES * LANE_W;
  localparam int LC_W = $clog2(LANE_W + 1);
  localparam int NW_W = $clog2(MAX_WORDS + 1);
  logic en, stall, adv, endp;
  logic [NUM_LANES-1:0][LC_W-1:0] lane_cnt;
  logic [CNT_W-1:0] word_cnt, sum;
  logic s0_val_q, s0_val_d, s0_pkt_q, s0_pkt_d, s0_last_q, s0_last_d;
  logic [PAD_W-1:0] s0_word_q, s0_word_d;
  logic s1_val_q, s1_val_d, s1_pkt_q, s1_pkt_d, s1_last_q, s1_last_d;
  logic [NUM_LANES-1:0][LC_W-1:0] s1_lane_q, s1_lane_d;
  logic s2_val_q, s2_val_d, s2_pkt_q, s2_pkt_d, s2_last_q, s2_last_d;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
  logic val_q, val_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, acc_q, acc_d;
  logic [NW_W-1:0] nw_q, nw_d;

  // A plain word meeting a partial packet holds S0-S2 for one beat while the partial sum flushes
  always_comb begin
    en = !val_q || data_rdy_i;
    stall = s2_val_q && !s2_pkt_q && nw_q != '0;
    adv = en && !stall;
    data_rdy_o = adv;
    s0_val_d = adv ? data_val_i : s0_val_q;
    s0_pkt_d = adv ? pkt_mode_i : s0_pkt_q;
    s0_last_d = adv ? data_last_i : s0_last_q;
    s0_word_d = adv ? PAD_W'(data_i ^ {WIDTH{mode_zeros_i}}) : s0_word_q;
    s1_val_d = adv ? s0_val_q : s1_val_q;
    s1_pkt_d = adv ? s0_pkt_q : s1_pkt_q;
    s1_last_d = adv ? s0_last_q : s1_last_q;
    s1_lane_d = adv ? lane_cnt : s1_lane_q;
    s2_val_d = adv ? s1_val_q : s2_val_q;
    s2_pkt_d = adv ? s1_pkt_q : s2_pkt_q;
    s2_last_d = adv ? s1_last_q : s2_last_q;
    s2_cnt_d = adv ? word_cnt : s2_cnt_q;
  end

  always_comb begin
    lane_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int b = 0; b < LANE_W; b++)
        lane_cnt[l] = lane_cnt[l] + LC_W'(s0_word_q[l*LANE_W+b]);
  end

  always_comb begin
    word_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++)
      word_cnt = word_cnt + CNT_W'(s1_lane_q[l]);
  end

  // Packet ends on last or when the MAX_WORDS-th word lands; only the latter flags overflow
  always_comb begin
    sum = acc_q + s2_cnt_q;
    endp = s2_last_q || nw_q == NW_W'(MAX_WORDS - 1);
    val_d = val_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    acc_d = acc_q;
    nw_d = nw_q;
    if (en) begin
      if (stall) begin
        val_d = 1'b1;
        cnt_d = acc_q;
        ovf_d = 1'b0;
        acc_d = '0;
        nw_d = '0;
      end else if (!s2_val_q) begin
        val_d = 1'b0;
      end else if (!s2_pkt_q) begin
        val_d = 1'b1;
        cnt_d = s2_cnt_q;
        ovf_d = 1'b0;
      end else begin
        val_d = endp;
        cnt_d = endp ? sum : cnt_q;
        ovf_d = endp ? !s2_last_q : ovf_q;
        acc_d = endp ? '0 : sum;
        nw_d = endp ? '0 : nw_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s0_val_q <= 1'b0;
      s0_pkt_q <= 1'b0;
      s0_last_q <= 1'b0;
      s0_word_q <= '0;
      s1_val_q <= 1'b0;
      s1_pkt_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_lane_q <= '0;
      s2_val_q <= 1'b0;
      s2_pkt_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_cnt_q <= '0;
      val_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      acc_q <= '0;
      nw_q <= '0;
    end else begin
      s0_val_q <= s0_val_d;
      s0_pkt_q <= s0_pkt_d;
      s0_last_q <= s0_last_d;
      s0_word_q <= s0_word_d;
      s1_val_q <= s1_val_d;
      s1_pkt_q <= s1_pkt_d;
      s1_last_q <= s1_last_d;
      s1_lane_q <= s1_lane_d;
      s2_val_q <= s2_val_d;
      s2_pkt_q <= s2_pkt_d;
      s2_last_q <= s2_last_d;
      s2_cnt_q <= s2_cnt_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
      nw_q <= nw_d;
    end
  end

  assign data_o = cnt_q;
  assign data_ovf_o = ovf_q;
  assign data_val_o = val_q;
endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// tb_bit_population_counter_pipe: scoreboard bench with a queue-based popcount/packet reference model
module tb_bit_population_counter_pipe;
  localparam int W = 16;
  localparam int MW = 4;
  localparam int CW = 7;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic mode_zeros, pkt_mode, data_last, data_val, data_rdy_i, data_rdy_o, data_ovf_o, data_val_o;
  logic [W-1:0] data_i;
  logic [CW-1:0] data_o;
  logic b_zeros, b_val, b_rdy_o, b_ovf, b_val_o;
  logic [9:0] b_data;
  logic [8:0] b_data_o;
  logic rand_rdy = 1'b0;
  logic rdy_force = 1'b1;
  int tests = 0;
  int fails = 0;
  int macc = 0;
  int mn = 0;
  typedef struct { int cnt; logic ovf; } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  bit_population_counter_pipe #(.WIDTH(W), .LANE_W(4), .MAX_WORDS(MW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .mode_zeros_i(mode_zeros), .pkt_mode_i(pkt_mode),
    .data_i(data_i), .data_last_i(data_last), .data_val_i(data_val), .data_rdy_o(data_rdy_o),
    .data_o(data_o), .data_ovf_o(data_ovf_o), .data_val_o(data_val_o), .data_rdy_i(data_rdy_i));

  bit_population_counter_pipe #(.WIDTH(10), .LANE_W(4), .MAX_WORDS(16)) dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .mode_zeros_i(b_zeros), .pkt_mode_i(1'b0),
    .data_i(b_data), .data_last_i(1'b0), .data_val_i(b_val), .data_rdy_o(b_rdy_o),
    .data_o(b_data_o), .data_ovf_o(b_ovf), .data_val_o(b_val_o), .data_rdy_i(1'b1));

  always @(posedge clk) begin
    #1;
    data_rdy_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted word is popcounted whole, packets summed, beats queued in order
  task automatic model_word(input logic [W-1:0] d, input logic z, input logic p, input logic l);
    int c;
    c = $countones(z ? ~d : d);
    if (p) begin
      macc += c;
      mn++;
      if (l || mn == MW) begin
        q.push_back('{macc, !l});
        macc = 0;
        mn = 0;
      end
    end else begin
      if (mn > 0) q.push_back('{macc, 1'b0});
      macc = 0;
      mn = 0;
      q.push_back('{c, 1'b0});
    end
  endtask

  always @(negedge clk) begin
    if (arst_n && data_val_o && data_rdy_i) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %0d expected no beat at %0t", data_o, $time);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_count", 32'(data_o), e.cnt);
        chk("beat_ovf", 32'(data_ovf_o), 32'(e.ovf));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic z, input logic p, input logic l);
    int k = 0;
    bit ok = 0;
    data_i = d;
    mode_zeros = z;
    pkt_mode = p;
    data_last = l;
    data_val = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = data_rdy_o;
      @(posedge clk);
      #1;
      k++;
    end
    if (ok) model_word(d, z, p, l);
    else chk("send_timeout", 32'(ok), 1);
    data_val = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic b_run(input logic [9:0] d, input logic z, input int exp);
    b_data = d;
    b_zeros = z;
    b_val = 1'b1;
    @(posedge clk);
    #1;
    b_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w10_val", 32'(b_val_o), 1);
    chk("w10_count", 32'(b_data_o), exp);
  endtask

  initial begin
    logic [CW-1:0] hold;
    int k;
    {mode_zeros, pkt_mode, data_last, data_val, b_zeros, b_val} = '0;
    data_i = '0;
    b_data = '0;
    data_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 32'(data_val_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_ovf", 32'(data_ovf_o), 0);
    chk("rst_rdy", 32'(data_rdy_o), 1);
    arst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_run(10'h001, 1'b1, 9);
    b_run(10'h3FF, 1'b1, 0);
    b_run(10'h3FF, 1'b0, 10);
    send(16'hFFFF, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'hA5A5, 1'b0, 1'b0, 1'b0);
    chk("latency_early", 32'(data_val_o), 0);
    @(posedge clk);
    #1;
    chk("latency_on_time", 32'(data_val_o), 1);
    chk("first_beat_16", 32'(data_o), 16);
    drain();
    send(16'h000F, 1'b0, 1'b1, 1'b0);
    send(16'h00FF, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) send(16'hFFFF, 1'b0, 1'b1, i == 4);
    drain();
    send(16'h0F0F, 1'b1, 1'b1, 1'b0);
    send(16'h0003, 1'b0, 1'b1, 1'b0);
    send(16'h00FF, 1'b0, 1'b0, 1'b0);
    send(16'h1111, 1'b1, 1'b0, 1'b0);
    drain();
    send(16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 1'b0, 1'b0, 1'b0);
    send(16'h0007, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rdy_force = 1'b0;
    data_rdy_i = 1'b0;
    hold = data_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdy_o", 32'(data_rdy_o), 0);
      chk("stall_val_o", 32'(data_val_o), 1);
      chk("stall_data_hold", 32'(data_o), 32'(hold));
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    send(16'h8001, 1'b0, 1'b0, 1'b0);
    drain();
    rdy_force = 1'b0;
    send(16'h00F0, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (!data_val_o && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("pre_reset_val", 32'(data_val_o), 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_reset_val", 32'(data_val_o), 0);
    q.delete();
    macc = 0;
    mn = 0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    rdy_force = 1'b1;
    send(16'h00FF, 1'b0, 1'b1, 1'b0);
    send(16'h0F0F, 1'b0, 1'b1, 1'b1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
